// File: rtl/riscv_pkg.sv
// Shared RV32 core constants used by the fetch stage.
package riscv_pkg;

  localparam int XLEN = 32;

  // Instruction buffer entries in the fetch unit; also caps requests in flight.
  localparam int IFU_FIFO_DEPTH = 4;

  // First instruction address fetched after reset.
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush. Flush beats push/pop in the same cycle.
// The head word is read straight from storage so it stays stable until popped.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic                           i_flush,
  input  logic [WIDTH-1:0]               i_data,
  output logic [WIDTH-1:0]               o_data,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_empty,
  output logic                           o_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only taken when a pop frees the slot the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    if (ptr == AW'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + AW'(1);
  endfunction

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy update; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Decoupled instruction fetch: issues sequential word requests, buffers the
// in-order responses and hands them to the core with their PC. A redirect
// flushes the buffer and marks every in-flight request as stale.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The request channel holds valid/addr stable until accepted (a redirect
// may retarget it). The response channel has no ready: every imem_rsp_valid
// cycle delivers one word. The instruction channel holds data/pc stable while
// inst_valid && !inst_ready.
module ifetch_unit #(
  parameter int                           XLEN       = riscv_pkg::XLEN,
  parameter logic [riscv_pkg::XLEN-1:0]   RESET_PC   = riscv_pkg::RESET_VECTOR,
  parameter int                           FIFO_DEPTH = riscv_pkg::IFU_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_head_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_empty;
  logic            w_fifo_full;
  logic [XLEN-1:0] w_fifo_data;
  logic [CW:0]     w_credit_used;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_out_next;
  logic [XLEN-1:0] w_target;

  // Every accepted request owns a buffer slot until it is popped, so the
  // buffer can never overflow. Only registered state feeds this.
  assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign imem_req_valid = !reset && (w_credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Stale responses (pending drops, or arriving during a redirect) are discarded.
  assign w_push = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
  assign w_pop  = inst_valid && inst_ready && !redirect_valid;

  assign w_out_next = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
  assign w_target   = {redirect_pc[XLEN-1:2], 2'b00};

  assign inst_valid = !reset && !w_fifo_empty;
  assign inst_data  = w_fifo_data;
  assign inst_pc    = r_head_pc;

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (imem_rsp_data),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  // PC, outstanding and drop tracking; redirect overrides increments.
  // On redirect, everything still in flight after this cycle is stale. Any
  // earlier pending drops are already part of that in-flight set, so the new
  // drop count is simply the next outstanding count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_head_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        r_fetch_pc <= w_target;
        r_head_pc  <= w_target;
        r_drop_cnt <= w_out_next;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
        if (w_pop) begin
          r_head_pc <= r_head_pc + XLEN'(4);
        end
        if (imem_rsp_valid && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
      end
    end
  end

  // Credit accounting must make a push into a full, non-popping buffer impossible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(w_push && w_fifo_full && !w_pop));
    end
  end

endmodule
